// File: rtl/matriz_varredura.sv
// Row-scanning driver for a 5x7 LED matrix: double-buffered frame input,
// prescaled row multiplexing with per-row blanking and tear-free frame swaps.
module matriz_varredura #(
   parameter int unsigned DIV    = 50000,
   parameter int unsigned BLANK  = 500,
   parameter logic        ROW_ON = 1'b0,
   parameter logic        COL_ON = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [34:0] frame_in,
   input  logic        frame_valid,
   output logic        frame_ready,
   output logic [6:0]  matriz_L,
   output logic [4:0]  matriz_C,
   output logic [2:0]  row_idx,
   output logic        frame_done
);
   localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
   localparam logic [2:0]    LAST_ROW = 3'd6;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    row_q, row_d;
   logic [34:0]   active_q, active_d;
   logic [34:0]   pend_q, pend_d;
   logic          pend_full_q, pend_full_d;
   logic          done_q, done_d;
   logic [6:0]    rows_q, rows_d;
   logic [4:0]    cols_q, cols_d;
   logic [4:0]    row_bits [8];
   logic          boundary;
   logic          accept;
   logic          swap;

   generate
      for (genvar gi = 0; gi < 7; gi++) begin : g_row
         assign row_bits[gi] = active_q[5*gi +: 5];
      end
   endgenerate
   assign row_bits[7] = 5'd0;

   assign boundary = (cnt_q == CNT_MAX) && (row_q == LAST_ROW);
   assign accept   = frame_valid && !pend_full_q;
   // While disabled there is no scan to tear, so a pending frame moves in at once
   assign swap     = pend_full_q && (!enable || boundary);

   always_comb begin
      cnt_d  = cnt_q;
      row_d  = row_q;
      done_d = 1'b0;
      if (!enable) begin
         cnt_d = '0;
         row_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         row_d = (row_q == LAST_ROW) ? 3'd0 : row_q + 3'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      // Predicting from next state lets the registered pulse line up with the boundary cycle
      done_d = (cnt_d == CNT_MAX) && (row_d == LAST_ROW);
   end

   always_comb begin
      active_d    = active_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      if (swap) begin
         active_d    = pend_q;
         pend_full_d = 1'b0;
      end
      if (accept) begin
         pend_d      = frame_in;
         pend_full_d = 1'b1;
      end
   end

   always_comb begin
      rows_d = {7{~ROW_ON}};
      cols_d = {5{~COL_ON}};
      if (enable && (cnt_q >= BLANK_C)) begin
         for (int r = 0; r < 7; r++) begin
            if (row_q == 3'(r)) rows_d[r] = ROW_ON;
         end
         for (int c = 0; c < 5; c++) begin
            cols_d[c] = row_bits[row_q][c] ? COL_ON : ~COL_ON;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         row_q       <= '0;
         active_q    <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         done_q      <= 1'b0;
         rows_q      <= {7{~ROW_ON}};
         cols_q      <= {5{~COL_ON}};
      end else begin
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         active_q    <= active_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         done_q      <= done_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
      end
   end

   assign frame_ready = !pend_full_q;
   assign matriz_L    = rows_q;
   assign matriz_C    = cols_q;
   assign row_idx     = row_q;
   assign frame_done  = done_q;

endmodule
